// File: rtl/result_writer_pkg.sv
// Shared types for the result cache-line writer: CCI-P channel-1 write header,
// writer FSM states and the header builder used at request issue.
package result_writer_pkg;

    localparam int WORDS_PER_CL = 8;
    localparam int CL_W         = 512;

    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FILL  = 2'd1,
        WR_DRAIN = 2'd2,
        WR_DONE  = 2'd3
    } t_wr_state;

    function automatic t_ccip_c1_ReqMemHdr mk_wr_hdr(input t_ccip_clAddr addr,
                                                     input t_ccip_mdata  idx);
        t_ccip_c1_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = eVC_VA;
        h.sop      = 1'b1;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_WRLINE_I;
        h.address  = addr;
        h.mdata    = idx;
        return h;
    endfunction

endpackage

// File: rtl/cl_line_fifo.sv
// Small synchronous FIFO of completed cache lines; a push while full is only
// taken when a pop happens in the same cycle.
module cl_line_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_rd_en   = i_pop && !o_empty;
    assign w_wr_en   = i_push && (!o_full || w_rd_en);

    // Line storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/result_cl_writer.sv
// Packs 64-bit match vectors into cache lines and issues CCI-P WrLine requests.
// Optional popcount of accepted words: define RESULT_CL_WRITER_POPCOUNT_EN.
module result_cl_writer
    import result_writer_pkg::*;
#(
    parameter int WORD_W       = 64,
    parameter int WORDS_PER_CL = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [41:0]        base_addr,
    input  logic [CNT_W-1:0]   total_words,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               c1_alm_full,
    input  logic               c1_wr_rsp,
    output logic               c1_valid,
    output t_ccip_c1_ReqMemHdr c1_hdr,
    output logic [CL_W-1:0]    c1_data,
    output logic [CNT_W-1:0]   lines_issued,
    output logic [CNT_W-1:0]   lines_acked,
    output logic               done,
    output logic               overflow,
    output logic [31:0]        match_count
);
    localparam int SLOT_W = $clog2(WORDS_PER_CL);

    t_wr_state            r_state;
    t_wr_state            w_state_nxt;
    logic [CNT_W-1:0]     r_words_in;
    logic [CNT_W-1:0]     r_total_words;
    logic [CNT_W-1:0]     r_lines_issued;
    logic [CNT_W-1:0]     r_lines_acked;
    t_ccip_clAddr         r_base_addr;
    logic [CL_W-1:0]      r_asm;
    logic [CL_W-1:0]      w_line;
    logic                 r_overflow;
    logic                 r_c1_valid;
    t_ccip_c1_ReqMemHdr   r_c1_hdr;
    logic [CL_W-1:0]      r_c1_data;
    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_last;
    logic                 w_push_need;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [SLOT_W-1:0]    w_slot;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CL_W-1:0]      w_fifo_rd;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    assign w_slot      = r_words_in[SLOT_W-1:0];
    assign w_last      = ((r_words_in + CNT_W'(1)) == r_total_words);
    assign w_push_need = w_accept && ((w_slot == SLOT_W'(WORDS_PER_CL - 1)) || w_last);
    assign w_pop       = (w_fifo_count != '0) && !c1_alm_full;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign w_drop      = w_push_need && w_fifo_full && !w_pop;
    assign w_push      = w_push_need && !w_drop;

    // Current assembly register with the incoming word merged into its slot.
    always_comb begin
        w_line = r_asm;
        w_line[w_slot*WORD_W +: WORD_W] = in_data;
    end

    cl_line_fifo #(.WIDTH(CL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_wr_data (w_line),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= WR_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WR_IDLE, WR_DONE: begin
                if (start) w_state_nxt = (total_words == '0) ? WR_DRAIN : WR_FILL;
                else       w_state_nxt = r_state;
            end
            WR_FILL: begin
                if (w_accept && w_last) w_state_nxt = WR_DRAIN;
                else                    w_state_nxt = WR_FILL;
            end
            WR_DRAIN: begin
                if (w_fifo_empty && !r_c1_valid && (r_lines_acked == r_lines_issued))
                    w_state_nxt = WR_DONE;
                else
                    w_state_nxt = WR_DRAIN;
            end
            default: w_state_nxt = WR_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_start_ok = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            WR_IDLE, WR_DONE: w_start_ok = start;
            WR_FILL:          w_accept   = in_valid;
            default: begin
                w_start_ok = 1'b0;
                w_accept   = 1'b0;
            end
        endcase
        w_done = (r_state == WR_DONE);
    end

    // Block counters, line assembly and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_words_in     <= '0;
            r_total_words  <= '0;
            r_lines_issued <= '0;
            r_lines_acked  <= '0;
            r_base_addr    <= '0;
            r_asm          <= '0;
            r_overflow     <= 1'b0;
        end else if (w_start_ok) begin
            r_words_in     <= '0;
            r_total_words  <= total_words;
            r_lines_issued <= '0;
            r_lines_acked  <= '0;
            r_base_addr    <= base_addr;
            r_asm          <= '0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_words_in <= r_words_in + CNT_W'(1);
                r_asm      <= w_push_need ? '0 : w_line;
            end
            if (w_drop)    r_overflow     <= 1'b1;
            if (w_pop)     r_lines_issued <= r_lines_issued + CNT_W'(1);
            if (c1_wr_rsp) r_lines_acked  <= r_lines_acked + CNT_W'(1);
        end
    end

    // Request issue: the line popped this cycle is presented for exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_c1_valid <= 1'b0;
            r_c1_hdr   <= '0;
            r_c1_data  <= '0;
        end else begin
            r_c1_valid <= w_pop;
            if (w_pop) begin
                r_c1_hdr  <= mk_wr_hdr(r_base_addr + 42'(r_lines_issued), 16'(r_lines_issued));
                r_c1_data <= w_fifo_rd;
            end
        end
    end

`ifdef RESULT_CL_WRITER_POPCOUNT_EN
    logic [31:0] r_match_count;
    logic [32:0] w_mc_sum;

    assign w_mc_sum = {1'b0, r_match_count} + 33'($countones(in_data));

    // Saturating count of set bits in words that made it into a line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 r_match_count <= 32'd0;
        else if (w_start_ok)          r_match_count <= 32'd0;
        else if (w_accept && !w_drop) r_match_count <= w_mc_sum[32] ? 32'hFFFF_FFFF : w_mc_sum[31:0];
    end

    assign match_count = r_match_count;
`else
    assign match_count = 32'd0;
`endif

    assign c1_valid     = r_c1_valid;
    assign c1_hdr       = r_c1_hdr;
    assign c1_data      = r_c1_data;
    assign lines_issued = r_lines_issued;
    assign lines_acked  = r_lines_acked;
    assign done         = w_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_result_cl_writer.sv
// Directed bench for result_cl_writer: line packing, issue gating on
// c1_alm_full, overflow, zero-length blocks, popcount and async reset.
module tb_result_cl_writer;
    import result_writer_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               start = 1'b0;
    logic [41:0]        base_addr = 42'd0;
    logic [15:0]        total_words = 16'd0;
    logic               in_valid = 1'b0;
    logic [63:0]        in_data = 64'd0;
    logic               c1_alm_full = 1'b0;
    logic               c1_wr_rsp = 1'b0;
    logic               c1_valid;
    t_ccip_c1_ReqMemHdr c1_hdr;
    logic [511:0]       c1_data;
    logic [15:0]        lines_issued;
    logic [15:0]        lines_acked;
    logic               done;
    logic               overflow;
    logic [31:0]        match_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_while_alm = 0;
    logic [41:0]  q_addr[$];
    logic [15:0]  q_mdata[$];
    logic [511:0] q_data[$];
    int           q_cyc[$];
    logic [511:0] line;
    logic [31:0]  mc_t1;
    logic [31:0]  mc_t6;

    result_cl_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .total_words  (total_words),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .c1_alm_full  (c1_alm_full),
        .c1_wr_rsp    (c1_wr_rsp),
        .c1_valid     (c1_valid),
        .c1_hdr       (c1_hdr),
        .c1_data      (c1_data),
        .lines_issued (lines_issued),
        .lines_acked  (lines_acked),
        .done         (done),
        .overflow     (overflow),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Request monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (c1_valid) begin
            q_addr.push_back(c1_hdr.address);
            q_mdata.push_back(c1_hdr.mdata);
            q_data.push_back(c1_data);
            q_cyc.push_back(cyc);
            if (c1_alm_full) valid_while_alm = valid_while_alm + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [41:0] b, input logic [15:0] n);
        base_addr   = b;
        total_words = n;
        start       = 1'b1;
        tick(1);
        start       = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic rsp(input int n);
        repeat (n) begin
            c1_wr_rsp = 1'b1;
            tick(1);
            c1_wr_rsp = 1'b0;
        end
    endtask

    task automatic clrq();
        q_addr.delete();
        q_mdata.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic wait_reqs(input string tag, input int n);
        for (int i = 0; i < 60 && q_addr.size() < n; i++) tick(1);
        chk({tag, "_nreq"}, q_addr.size(), n);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !done; i++) tick(1);
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef RESULT_CL_WRITER_POPCOUNT_EN
        mc_t1 = 32'd12;
        mc_t6 = 32'd512;
`else
        mc_t1 = 32'd0;
        mc_t6 = 32'd0;
`endif
        #1 reset_n = 1'b0;
        tick(2);
        chk("rst_valid", c1_valid, 0);
        chk("rst_hdr", c1_hdr, 0);
        chk("rst_data", c1_data[127:0], 0);
        chk("rst_done", done, 0);
        chk("rst_iss", lines_issued, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        tick(1);

        // One full line.
        do_start(42'h1000, 16'd8);
        for (int i = 0; i < 8; i++) send(64'(i));
        wait_reqs("t1", 1);
        chk("t1_addr", q_addr[0], 42'h1000);
        chk("t1_mdata", q_mdata[0], 0);
        line = q_data[0];
        for (int k = 0; k < 8; k++) chk($sformatf("t1_w%0d", k), line[k*64 +: 64], k);
        chk("t1_iss", lines_issued, 1);
        chk("t1_done_early", done, 0);
        chk("t1_mc", match_count, mc_t1);
        rsp(1);
        wait_done("t1");
        chk("t1_ack1", lines_acked, 1);
        rsp(1);
        tick(1);
        chk("t1_ack2", lines_acked, 2);
        chk("t1_done_hold", done, 1);

        // Partial second line.
        clrq();
        do_start(42'h2000, 16'd10);
        for (int i = 0; i < 10; i++) send(64'h100 + 64'(i));
        wait_reqs("t2", 2);
        chk("t2_addr0", q_addr[0], 42'h2000);
        chk("t2_addr1", q_addr[1], 42'h2001);
        chk("t2_mdata1", q_mdata[1], 1);
        line = q_data[1];
        chk("t2_s0", line[63:0], 64'h108);
        chk("t2_s1", line[127:64], 64'h109);
        chk("t2_rest_lo", line[255:128], 0);
        chk("t2_rest_hi", line[511:384], 0);
        chk("t2_iss", lines_issued, 2);
        rsp(2);
        wait_done("t2");

        // Backpressure for ~20 cycles then back-to-back issue.
        clrq();
        valid_while_alm = 0;
        c1_alm_full = 1'b1;
        do_start(42'h4000, 16'd16);
        for (int i = 0; i < 16; i++) send(64'(i));
        tick(3);
        chk("t3_noreq", q_addr.size(), 0);
        chk("t3_ovf", overflow, 0);
        c1_alm_full = 1'b0;
        wait_reqs("t3", 2);
        chk("t3_b2b", q_cyc[1] - q_cyc[0], 1);
        chk("t3_vwa", valid_while_alm, 0);
        chk("t3_addr1", q_addr[1], 42'h4001);
        rsp(2);
        wait_done("t3");

        // Overflow with issue stuck.
        clrq();
        c1_alm_full = 1'b1;
        do_start(42'h3000, 16'd48);
        for (int i = 0; i < 32; i++) send(64'(i));
        chk("t4_ovf_pre", overflow, 0);
        for (int i = 32; i < 40; i++) send(64'(i));
        chk("t4_ovf", overflow, 1);
        for (int i = 40; i < 48; i++) send(64'(i));
        tick(5);
        chk("t4_drain", done, 0);
        chk("t4_iss0", lines_issued, 0);
        c1_alm_full = 1'b0;
        wait_reqs("t4", 4);
        tick(5);
        chk("t4_nreq_final", q_addr.size(), 4);
        chk("t4_addr3", q_addr[3], 42'h3003);
        line = q_data[3];
        chk("t4_l3w0", line[63:0], 64'd24);
        rsp(4);
        wait_done("t4");
        chk("t4_ovf_sticky", overflow, 1);

        // Zero-length block.
        clrq();
        do_start(42'h0, 16'd0);
        chk("t5_drain", done, 0);
        chk("t5_ovf_clr", overflow, 0);
        tick(1);
        chk("t5_done", done, 1);
        chk("t5_noreq", q_addr.size(), 0);

        // Popcount, then async reset mid-fill.
        clrq();
        do_start(42'h5000, 16'd16);
        for (int i = 0; i < 8; i++) send(64'hFFFF_FFFF_FFFF_FFFF);
        wait_reqs("t6", 1);
        chk("t6_mc", match_count, mc_t6);
        line = q_data[0];
        chk("t6_w7", line[511:448], 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) send(64'h5);
        chk("t6_iss_pre", lines_issued, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", c1_valid, 0);
        chk("t6_rst_hdr", c1_hdr, 0);
        chk("t6_rst_data", c1_data[511:384], 0);
        chk("t6_rst_iss", lines_issued, 0);
        chk("t6_rst_mc", match_count, 0);
        chk("t6_rst_done", done, 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        do_start(42'h0, 16'd0);
        tick(1);
        chk("t6_recover", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_cl_writer.md
# result_cl_writer

Downstream stage of the filter-scan AFU. Consumes the 64-bit match bit-vectors produced per read response and packs eight of them into one 512-bit cache line. Issues CCI-P channel-1 WrLine requests into the software-supplied result buffer and tracks write acknowledgements, so software can poll for full write completion of a partition block.

## Interface
Parameters:
- WORD_W, 64: bit-vector width per input beat.
- WORDS_PER_CL, 8: words packed per cache line; WORD_W*WORDS_PER_CL = 512.
- FIFO_DEPTH, 4: completed-line buffer depth, power of two.
- CNT_W, 16: width of word/line counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and total_words, clears counters.
- base_addr  in  42  result buffer cache-line address (t_ccip_clAddr).
- total_words  in  CNT_W  bit-vectors expected for this block.
- in_valid  in  1  input word valid; no ready, producer cannot stall.
- in_data  in  WORD_W  bit-vector result.
- c1_alm_full  in  1  c1TxAlmFull from FIU.
- c1_wr_rsp  in  1  write response received (cci_c1Rx_isWriteRsp).
- c1_valid  out  1  write request valid.
- c1_hdr  out  $bits(t_ccip_c1_ReqMemHdr)  write header.
- c1_data  out  512  line data.
- lines_issued  out  CNT_W  write requests sent this block.
- lines_acked  out  CNT_W  write responses counted this block.
- done  out  1  all lines written and acknowledged.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- match_count  out  32  set bits across all accepted words (see Configuration).

## Operation
- States: IDLE, FILL, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE: start → FILL, except when total_words == 0, where start → DRAIN. start clears every counter, assembly register, overflow and match_count. start in FILL or DRAIN is ignored.
- FILL: each in_valid word is written to slot k = words_in mod WORDS_PER_CL, bits [64k +: 64]. Slot 0 holds the first word of the line.
- When slot 7 fills, or the last word arrives (words_in+1 == total_words), the line is pushed to the FIFO with unused slots zero. The assembly register clears.
- After the last word is accepted: → DRAIN.
- Words arriving in FILL when the FIFO is full and a push is required are dropped. overflow is set and words_in still increments, so termination is preserved.
- in_valid outside FILL is ignored.
- DRAIN → DONE when the FIFO is empty, no request is pending, and lines_acked == lines_issued.
- Request header:
  - vc_sel eVC_VA, sop 1, cl_len eCL_LEN_1, req_type eREQ_WRLINE_I.
  - address = base_addr + line_idx, modulo 2^42.
  - mdata = line_idx[15:0].
  - line_idx increments per issued request.
- Issue rule: pop the FIFO and present the line when the FIFO is non-empty and c1_alm_full is low. One line per cycle maximum.
- done = (state == DONE).

## Timing
- Reset values: c1_valid 0, c1_hdr 0, c1_data 0, all counters 0, done 0, overflow 0, match_count 0.
- c1_valid, c1_hdr and c1_data are registered. c1_valid is high for exactly one cycle per request.
- Latency: completing word sampled at edge t → FIFO non-empty after t → c1_valid high after edge t+1, if c1_alm_full is low at t+1.
- c1_alm_full is sampled at the issue edge. While it is high no pop occurs, and an in-flight c1_valid is not retracted.
- Simultaneous FIFO push and pop in the same cycle is legal at full occupancy; no overflow results.
- c1_wr_rsp is counted in any state, including the cycle of the DRAIN→DONE check. A response in the same cycle as start is discarded by the clear.
- Asynchronous reset mid-block aborts immediately; outstanding FIU responses after reset are counted but ignored until start.

## Configuration
- RESULT_CL_WRITER_POPCOUNT_EN:
  - Defined: match_count accumulates $countones(in_data) for every accepted, non-dropped word. Saturates at 2^32−1 and is registered one cycle after the word.
  - Undefined: match_count is tied to 0 and no popcount logic is built.

## Structure
- Shared package result_writer_pkg holds:
  - t_wr_state enum.
  - WORDS_PER_CL and CL_W = 512.
  - Function mk_wr_hdr(addr, idx) returning t_ccip_c1_ReqMemHdr.
- One sub-module, cl_line_fifo: synchronous FIFO of 512-bit lines, depth FIFO_DEPTH, with full/empty/count and async active-low reset.

## Test plan
- total_words=8, base_addr=0x1000, in_data=i for i=0..7, alm_full=0 → one request: address 0x1000, mdata 0, data word k = k. Two responses → done after lines_acked=1.
- total_words=10 → two lines. Second line holds words 8 and 9 in slots 0–1, rest zero, address base+1. lines_issued=2.
- total_words=16 with alm_full high for 20 cycles → no c1_valid while high, no overflow with FIFO_DEPTH=4, then two back-to-back requests.
- total_words=48, alm_full stuck high, FIFO_DEPTH=4 → overflow=1 after the fifth line completes. The state still reaches DRAIN and stays there until alm_full drops.
- start with total_words=0 → DONE two cycles later, no c1_valid.
- POPCOUNT_EN, 8 words of 0xFFFF_FFFF_FFFF_FFFF → match_count=512. reset_n pulse mid-FILL → all outputs return to reset values.
